// File: rtl/bus_source_arbiter.sv
// Registered N_SRC-way bus-source arbiter: fixed-priority or round-robin, with lock hold and conflict flag.
// Define BUSARB_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module bus_source_arbiter #(
   parameter int N_SRC       = 24,
   parameter int SEL_W       = $clog2(N_SRC),
   parameter int DEFAULT_SEL = 0,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] req,
   input  logic             mode,
   input  logic             lock,
   output logic [SEL_W-1:0] sel,
   output logic [N_SRC-1:0] grant_oh,
   output logic             sel_valid,
`ifdef BUSARB_CONFLICT_CNT_EN
   output logic             conflict,
   output logic [CNT_W-1:0] conflict_cnt
`else
   output logic             conflict
`endif
);

   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] win;
   logic [SEL_W-1:0] cand;
   logic [SEL_W-1:0] nxt_ptr;
   logic [N_SRC-1:0] win_oh;
   logic             found;
   logic             multi;
   int unsigned      idx;

   // Search order starts at rr_ptr in round-robin mode, at 0 in fixed mode.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      cand  = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         idx = mode ? (int'(rr_ptr) + i) : i;
         if (idx >= N_SRC) idx = idx - N_SRC;
         cand = SEL_W'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      win_oh  = N_SRC'(1) << win;
      nxt_ptr = (win == SEL_W'(N_SRC - 1)) ? '0 : win + SEL_W'(1);
      multi   = |(req & (req - N_SRC'(1)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel       <= SEL_W'(DEFAULT_SEL);
         grant_oh  <= '0;
         sel_valid <= 1'b0;
         conflict  <= 1'b0;
         rr_ptr    <= '0;
      end else begin
         conflict <= multi;
         if (!(lock && sel_valid)) begin
            if (found) begin
               sel       <= win;
               grant_oh  <= win_oh;
               sel_valid <= 1'b1;
               rr_ptr    <= nxt_ptr;
            end else begin
               sel       <= SEL_W'(DEFAULT_SEL);
               grant_oh  <= '0;
               sel_valid <= 1'b0;
            end
         end
      end
   end

`ifdef BUSARB_CONFLICT_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         conflict_cnt <= '0;
      else if (multi && (conflict_cnt != '1))
         conflict_cnt <= conflict_cnt + CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Self-checking bench for bus_source_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_bus_source_arbiter;

   localparam int N   = 24;
   localparam int DEF = 0;
   localparam int CW  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req = '0;
   logic          mode = 1'b0;
   logic          lock = 1'b0;
   logic [4:0]    sel;
   logic [N-1:0]  grant_oh;
   logic          sel_valid;
   logic          conflict;
`ifdef BUSARB_CONFLICT_CNT_EN
   logic [CW-1:0] conflict_cnt;
`endif

   int vectors = 0;
   int fails   = 0;

   // reference model state
   int m_sel   = DEF;
   bit m_valid = 0;
   int m_ptr   = 0;
   bit m_conf  = 0;
   int m_cnt   = 0;

   always #5 clk = ~clk;

`ifdef BUSARB_CONFLICT_CNT_EN
   bus_source_arbiter #(.N_SRC(N), .DEFAULT_SEL(DEF), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .lock(lock),
      .sel(sel), .grant_oh(grant_oh), .sel_valid(sel_valid),
      .conflict(conflict), .conflict_cnt(conflict_cnt));
`else
   bus_source_arbiter #(.N_SRC(N), .DEFAULT_SEL(DEF)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .lock(lock),
      .sel(sel), .grant_oh(grant_oh), .sel_valid(sel_valid),
      .conflict(conflict));
`endif

   function automatic int arb(input logic [N-1:0] r, input bit rr, input int ptr);
      for (int k = 0; k < N; k++) begin
         int j;
         j = rr ? (ptr + k) % N : k;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] exp_oh;
      exp_oh = m_valid ? (32'd1 << m_sel) : 32'd0;
      check("sel", 32'(sel), 32'(m_sel));
      check("grant_oh", 32'(grant_oh), exp_oh);
      check("sel_valid", 32'(sel_valid), 32'(m_valid));
      check("conflict", 32'(conflict), 32'(m_conf));
`ifdef BUSARB_CONFLICT_CNT_EN
      check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
`endif
   endtask

   task automatic model_reset();
      m_sel = DEF; m_valid = 0; m_ptr = 0; m_conf = 0; m_cnt = 0;
   endtask

   // Called just after a negedge: drive, take one posedge, update model, check.
   task automatic apply(input logic [N-1:0] r, input bit md, input bit lk);
      int g;
      req = r; mode = md; lock = lk;
      @(posedge clk);
      m_conf = ($countones(r) >= 2);
      if (!(lk && m_valid)) begin
         g = arb(r, md, m_ptr);
         if (g >= 0) begin
            m_sel = g; m_valid = 1; m_ptr = (g + 1) % N;
         end else begin
            m_sel = DEF; m_valid = 0;
         end
      end
      if (m_conf && m_cnt < (1 << CW) - 1) m_cnt++;
      #1;
      check_all();
      @(negedge clk);
   endtask

   // Asserts reset between edges, checks outputs immediately, releases on the next negedge.
   task automatic pulse_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] r;
      int kind;

      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // fixed priority: bits 3 and 17
      apply((N'(1) << 3) | (N'(1) << 17), 1'b0, 1'b0);
      check("t1_sel", 32'(sel), 32'd3);
      check("t1_grant", 32'(grant_oh), 32'h8);
      check("t1_conflict", 32'(conflict), 32'd1);

      // round-robin from a fresh pointer
      pulse_reset();
      r = (N'(1) << 2) | (N'(1) << 5) | (N'(1) << 9);
      apply(r, 1'b1, 1'b0); check("t2_sel_a", 32'(sel), 32'd2);
      apply(r, 1'b1, 1'b0); check("t2_sel_b", 32'(sel), 32'd5);
      apply(r, 1'b1, 1'b0); check("t2_sel_c", 32'(sel), 32'd9);
      apply(r, 1'b1, 1'b0); check("t2_sel_d", 32'(sel), 32'd2);
      apply(r, 1'b1, 1'b0); check("t2_ptr3", 32'(sel), 32'd5);
      apply(N'(1) << 22, 1'b1, 1'b0); check("t2_sel22", 32'(sel), 32'd22);
      apply(N'(1), 1'b1, 1'b0); check("t2_wrap", 32'(sel), 32'd0);

      // lock hold and release
      apply(N'(1) << 5, 1'b0, 1'b0); check("t3_grant5", 32'(sel), 32'd5);
      for (int i = 0; i < 3; i++) begin
         apply(N'(1) << 1, 1'b0, 1'b1);
         check("t3_hold", 32'(sel), 32'd5);
      end
      apply(N'(1) << 1, 1'b0, 1'b0); check("t3_release", 32'(sel), 32'd1);

      // empty request, then lock while nothing is granted
      apply('0, 1'b1, 1'b0);
      check("t4_valid", 32'(sel_valid), 32'd0);
      check("t4_sel", 32'(sel), 32'(DEF));
      apply(N'(1) << 7, 1'b1, 1'b1); check("t4_lock_ign", 32'(sel), 32'd7);

      // reset during round-robin traffic
      apply(N'(1) << 10, 1'b1, 1'b0);
      apply((N'(1) << 4) | (N'(1) << 12), 1'b1, 1'b0);
      pulse_reset();
      check("t5_rst_valid", 32'(sel_valid), 32'd0);
      apply((N'(1) << 5) | (N'(1) << 15), 1'b1, 1'b0);
      check("t5_from0", 32'(sel), 32'd5);

      // conflict counting / saturation
      pulse_reset();
      for (int i = 0; i < 5; i++) begin
         apply(N'(3), 1'b0, 1'b0);
         check("t6_conflict", 32'(conflict), 32'd1);
`ifdef BUSARB_CONFLICT_CNT_EN
         check("t6_cnt", 32'(conflict_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
`endif
      end

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0: r = '0;
            1: r = N'(1) << $urandom_range(0, N - 1);
            2: r = N'($urandom) & N'($urandom) & N'($urandom);
            default: r = N'($urandom);
         endcase
         apply(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
         if (n == 200) pulse_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
